store_narrow: RTL and testbench

//  Store-path width narrower for the multi-cycle CPU: the write-side counterpart of the

---
 rtl/cpu_pkg.sv | 37 +++
 rtl/lane_merge.sv | 27 ++
 rtl/store_narrow.sv | 94 +++++++++
 tb/tb_store_narrow.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared store-path encodings for the multi-cycle CPU.
// Op codes, store FSM states and the alignment check.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_SW  = 2'b00,
    ST_SH  = 2'b01,
    ST_SB  = 2'b10,
    ST_RSV = 2'b11
  } st_op_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_MRG  = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } st_state_t;

  // High when the request cannot be performed (misaligned or reserved op)
  function automatic logic st_bad(
    input st_op_t     op,
    input logic [1:0] lo
  );
    logic bad;
    bad = 1'b0;
    unique case (op)
      ST_SW:   bad = (lo != 2'b00);
      ST_SH:   bad = lo[0];
      ST_SB:   bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lane_merge.sv
// Replaces one little-endian lane of a memory word with store data.
// SW passes the new data through untouched.
module lane_merge
  import cpu_pkg::*;
(
  input  logic [31:0] i_old,
  input  logic [31:0] i_data,
  input  st_op_t      i_op,
  input  logic [1:0]  i_lane,
  output logic [31:0] o_word
);

  always_comb begin
    o_word = i_old;
    unique case (i_op)
      ST_SB: o_word[{i_lane, 3'b000} +: 8] = i_data[7:0];
      ST_SH: begin
        if (i_lane[1])
          o_word[31:16] = i_data[15:0];
        else
          o_word[15:0] = i_data[15:0];
      end
      default: o_word = i_data;
    endcase
  end

endmodule

// File: rtl/store_narrow.sv
// Store-path width narrower: SW direct, SB/SH via read-modify-write.
// Memory has no byte enables, so sub-word stores merge into the old word.
module store_narrow
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output logic [31:0]       mem_wdata
);

  st_state_t         r_state;
  st_state_t         w_next;
  st_op_t            r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       w_merged;
  logic              w_take;

  assign w_take = (r_state == S_IDLE) && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (st_bad(st_op_t'(op), addr[1:0]))
            w_next = S_ERR;
          else if (op == ST_SW)
            w_next = S_WR;
          else
            w_next = S_RD;
        end
      end
      S_RD:    w_next = S_MRG;
      S_MRG:   w_next = S_WR;
      S_WR:    w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // r_wdata holds the source word, then the merged word after MRG
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op    <= ST_SW;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_take) begin
      r_op    <= st_op_t'(op);
      r_addr  <= addr;
      r_wdata <= wdata;
    end else if (r_state == S_MRG) begin
      r_wdata <= w_merged;
    end
  end

  lane_merge u_merge (
    .i_old  (mem_rdata),
    .i_data (r_wdata),
    .i_op   (r_op),
    .i_lane (r_addr[1:0]),
    .o_word (w_merged)
  );

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE) || (r_state == S_ERR);
  assign err       = (r_state == S_ERR);
  assign mem_re    = (r_state == S_RD);
  assign mem_we    = (r_state == S_WR);
  assign mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
  assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_store_narrow.sv
// Bench for store_narrow: word memory model plus write scoreboard.
// Expected writes are queued at issue time and popped on each mem_we.
module tb_store_narrow;

  localparam logic [1:0] OP_SW = 2'b00;
  localparam logic [1:0] OP_SH = 2'b01;
  localparam logic [1:0] OP_SB = 2'b10;
  localparam logic [1:0] OP_RV = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done, err;
  logic [31:0] mem_addr;
  logic        mem_re, mem_we;
  logic [31:0] mem_rdata;
  logic [31:0] mem_wdata;

  int total = 0;
  int bad = 0;
  int re_cnt = 0;
  int we_cnt = 0;
  logic [63:0] exp_q[$];
  logic [31:0] mem [64];

  store_narrow #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata)
  );

  always #5 clk = ~clk;

  // Word memory: read data appears the cycle after mem_re
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++)
        mem[i] <= 32'h5A5A0000 ^ (i * 32'h01010101);
      mem[1]    <= 32'hAAAABBBB;
      mem[8]    <= 32'h11223344;
      mem_rdata <= '0;
    end else begin
      if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr[7:2]];
    end
  end

  always @(negedge clk) begin
    if (mem_re && mem_we) begin
      total++;
      bad++;
      $display("FAIL strobe_overlap: re=%b we=%b required not both", mem_re, mem_we);
    end
    if (mem_re) re_cnt++;
    if (mem_we) begin
      logic [63:0] e;
      we_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: addr=%h data=%h", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          bad++;
          $display("FAIL write: got %h/%h required %h/%h",
                   mem_addr, mem_wdata, e[63:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] model(
    input logic [31:0] old,
    input logic [31:0] d,
    input logic [1:0]  o,
    input logic [1:0]  lo
  );
    logic [31:0] mask;
    int          sh;
    mask = (o == OP_SB) ? 32'hFF : (o == OP_SH) ? 32'hFFFF : 32'hFFFFFFFF;
    sh = (o == OP_SB) ? lo * 8 : (o == OP_SH) ? lo[1] * 16 : 0;
    return (old & ~(mask << sh)) | ((d & mask) << sh);
  endfunction

  // Pulses start for one cycle; returns at the first negedge after acceptance
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    addr  = a;
    wdata = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 16) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({busy, done, err, mem_re, mem_we} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b required 00000", {busy, done, err, mem_re, mem_we});
    end
    total++;
    if ({mem_addr, mem_wdata} !== 64'h0) begin
      bad++;
      $display("FAIL reset_bus: got %h/%h required 0/0", mem_addr, mem_wdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_sw();
    int cyc;
    int re0;
    re0 = re_cnt;
    exp_q.push_back({32'h10, 32'hDEADBEEF});
    issue(OP_SW, 32'h10, 32'hDEADBEEF);
    wait_done(cyc);
    total++;
    if (cyc !== 2 || err !== 1'b0) begin
      bad++;
      $display("FAIL sw_latency: got cyc=%0d err=%b required 2/0", cyc, err);
    end
    total++;
    if (re_cnt - re0 !== 0) begin
      bad++;
      $display("FAIL sw_no_read: got %0d reads required 0", re_cnt - re0);
    end
  endtask

  task automatic test_sb();
    int cyc;
    exp_q.push_back({32'h20, 32'hAB223344});
    issue(OP_SB, 32'h23, 32'h000000AB);
    total++;
    if (mem_re !== 1'b1 || mem_addr !== 32'h20) begin
      bad++;
      $display("FAIL sb_read: got re=%b addr=%h required 1/00000020", mem_re, mem_addr);
    end
    wait_done(cyc);
    total++;
    if (cyc !== 4 || err !== 1'b0) begin
      bad++;
      $display("FAIL sb_latency: got cyc=%0d err=%b required 4/0", cyc, err);
    end
  endtask

  task automatic test_sh();
    int cyc;
    exp_q.push_back({32'h04, 32'h5566BBBB});
    issue(OP_SH, 32'h06, 32'hFFFF5566);
    wait_done(cyc);
    total++;
    if (cyc !== 4 || err !== 1'b0) begin
      bad++;
      $display("FAIL sh_latency: got cyc=%0d err=%b required 4/0", cyc, err);
    end
  endtask

  task automatic test_errors();
    logic [1:0]  ops [3];
    logic [31:0] ads [3];
    int          cyc;
    int          re0, we0;
    ops[0] = OP_SW; ads[0] = 32'h02;
    ops[1] = OP_SH; ads[1] = 32'h05;
    ops[2] = OP_RV; ads[2] = 32'h08;
    for (int i = 0; i < 3; i++) begin
      re0 = re_cnt;
      we0 = we_cnt;
      issue(ops[i], ads[i], 32'hCAFEF00D);
      wait_done(cyc);
      total++;
      if (cyc !== 1 || err !== 1'b1) begin
        bad++;
        $display("FAIL err_%0d: got cyc=%0d err=%b required 1/1", i, cyc, err);
      end
      @(negedge clk);
      total++;
      if (re_cnt - re0 !== 0 || we_cnt - we0 !== 0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL err_%0d_mem: got re=%0d we=%0d busy=%b required 0/0/0",
                 i, re_cnt - re0, we_cnt - we0, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    exp_q.push_back({32'h20, 32'hAB227744});
    issue(OP_SB, 32'h21, 32'h00000077);
    start = 1'b1;
    op    = OP_SW;
    addr  = 32'h40;
    wdata = 32'h12345678;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 3;
    while (!done && cyc < 16) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (cyc !== 4 || err !== 1'b0) begin
      bad++;
      $display("FAIL ignore_start: got cyc=%0d err=%b required 4/0", cyc, err);
    end
    exp_q.push_back({32'h20, 32'hABCC7744});
    issue(OP_SB, 32'h22, 32'h000000CC);
    total++;
    if (mem_re !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accept: got re=%b required 1", mem_re);
    end
    wait_done(cyc);
    total++;
    if (cyc !== 4 || err !== 1'b0) begin
      bad++;
      $display("FAIL b2b_latency: got cyc=%0d err=%b required 4/0", cyc, err);
    end
  endtask

  task automatic test_lanes();
    int          cyc;
    logic [1:0]  o;
    logic [31:0] a, d, e;
    for (int i = 0; i < 6; i++) begin
      o = (i < 4) ? OP_SB : OP_SH;
      a = 32'h30 + ((i < 4) ? i : (i - 4) * 2);
      d = $urandom;
      e = model(mem[12], d, o, a[1:0]);
      exp_q.push_back({32'h30, e});
      issue(o, a, d);
      wait_done(cyc);
      total++;
      if (cyc !== 4 || err !== 1'b0) begin
        bad++;
        $display("FAIL lane_%0d: got cyc=%0d err=%b required 4/0", i, cyc, err);
      end
    end
  endtask

  task automatic test_rst_mid();
    int cyc;
    issue(OP_SB, 32'h31, 32'h000000EE);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({busy, done, err, mem_re, mem_we} !== 5'b0 || {mem_addr, mem_wdata} !== 64'h0) begin
      bad++;
      $display("FAIL rst_mid: got %b %h/%h required 00000 0/0",
               {busy, done, err, mem_re, mem_we}, mem_addr, mem_wdata);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back({32'h3C, 32'h0BADF00D});
    issue(OP_SW, 32'h3C, 32'h0BADF00D);
    wait_done(cyc);
    total++;
    if (cyc !== 2 || err !== 1'b0) begin
      bad++;
      $display("FAIL post_rst_sw: got cyc=%0d err=%b required 2/0", cyc, err);
    end
  endtask

  initial begin
    test_reset();
    test_sw();
    test_sb();
    test_sh();
    test_errors();
    test_back_to_back();
    test_lanes();
    test_rst_mid();
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL missing_writes: got %0d pending required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
